// File: rtl/decode_regread_stage_pkg.sv
// Shared definitions for the decode / register-read stage: instruction field
// positions, RV64 major opcodes and the registered field bundle.
package decode_regread_stage_pkg;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
    } decoded_fields_t;

    function automatic decoded_fields_t slice_fields(input logic [31:0] insn);
        decoded_fields_t f;
        f.opcode = insn[OPCODE_LSB +: 7];
        f.rd     = insn[RD_LSB     +: 5];
        f.funct3 = insn[FUNCT3_LSB +: 3];
        f.rs1    = insn[RS1_LSB    +: 5];
        f.rs2    = insn[RS2_LSB    +: 5];
        f.funct7 = insn[FUNCT7_LSB +: 7];
        return f;
    endfunction

endpackage

// File: rtl/decode_regread_stage_regfile_bank.sv
// Architectural register file: NREGS flops of XLEN bits, x0 hardwired to zero,
// two combinational read ports with write-through bypass, one write port.
module regfile_bank #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               rs1_idx,
    input  logic [4:0]               rs2_idx,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]          wr_data
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      rd_idx  [2];
    logic [XLEN-1:0] rd_data [2];

    assign rd_idx[0] = rs1_idx;
    assign rd_idx[1] = rs2_idx;
    assign rs1_data  = rd_data[0];
    assign rs2_data  = rd_data[1];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            // Entry 0 is never written, so it stays at its reset value of zero.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regs[gi] <= '0;
                end else if (wr_en && (gi != 0) && (wr_addr == AW'(gi))) begin
                    regs[gi] <= wr_data;
                end
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic          in_range;
            logic [AW-1:0] idx;
            assign in_range = ((rd_idx[gi] >> AW) == '0);
            assign idx      = rd_idx[gi][AW-1:0];
            // Out-of-range indices and x0 read zero; a same-edge write wins over the array.
            assign rd_data[gi] = (!in_range || (idx == '0)) ? '0 :
                                 (wr_en && (wr_addr == idx)) ? wr_data : regs[idx];
        end
    endgenerate

endmodule

// File: rtl/decode_regread_stage.sv
// Decode / register-read pipeline stage: slices the instruction, reads both
// operands and holds the result in a one-deep valid/ready output register.
module decode_regread_stage
    import decode_regread_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data
);
    decoded_fields_t in_fields;
    decoded_fields_t fields_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;
    logic [XLEN-1:0] rs1_rd_data;
    logic [XLEN-1:0] rs2_rd_data;
    logic            capture;
    logic            stalled;
    logic            held_hit1;
    logic            held_hit2;

    assign in_fields = slice_fields(instruction);
    assign in_ready  = !out_valid_reg || out_ready;
    assign capture   = in_valid && in_ready && !flush;
    assign stalled   = out_valid_reg && !out_ready;

    // A held operand tracks writes to its (in-range, nonzero) source register.
    assign held_hit1 = wr_en && ((fields_reg.rs1 >> AW) == '0) && (fields_reg.rs1 != '0)
                       && (fields_reg.rs1[AW-1:0] == wr_addr);
    assign held_hit2 = wr_en && ((fields_reg.rs2 >> AW) == '0) && (fields_reg.rs2 != '0)
                       && (fields_reg.rs2[AW-1:0] == wr_addr);

    regfile_bank #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_idx  (in_fields.rs1),
        .rs2_idx  (in_fields.rs2),
        .rs1_data (rs1_rd_data),
        .rs2_data (rs2_rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            fields_reg    <= '0;
            rs1_data_reg  <= '0;
            rs2_data_reg  <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            out_valid_reg <= 1'b1;
            fields_reg    <= in_fields;
            rs1_data_reg  <= rs1_rd_data;
            rs2_data_reg  <= rs2_rd_data;
        end else if (stalled) begin
            if (held_hit1) begin
                rs1_data_reg <= wr_data;
            end
            if (held_hit2) begin
                rs2_data_reg <= wr_data;
            end
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_opcode   = fields_reg.opcode;
    assign out_rd       = fields_reg.rd;
    assign out_funct3   = fields_reg.funct3;
    assign out_funct7   = fields_reg.funct7;
    assign out_rs1      = fields_reg.rs1;
    assign out_rs2      = fields_reg.rs2;
    assign out_rs1_data = rs1_data_reg;
    assign out_rs2_data = rs2_data_reg;

endmodule

// File: tb/tb_decode_regread_stage.sv
// Directed bench for decode_regread_stage: a 32-register instance for the main
// flow and a 16-register instance for out-of-range index handling.
module tb_decode_regread_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-register instance
    logic        reset, in_valid, in_ready, flush, wr_en, out_valid, out_ready;
    logic [31:0] instruction;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data, out_rs1_data, out_rs2_data;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;

    decode_regread_stage #(.XLEN(64), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
    );

    // 16-register instance
    logic        e_reset, e_in_valid, e_in_ready, e_flush, e_wr_en, e_out_valid, e_out_ready;
    logic [31:0] e_instruction;
    logic [3:0]  e_wr_addr;
    logic [63:0] e_wr_data, e_out_rs1_data, e_out_rs2_data;
    logic [6:0]  e_out_opcode, e_out_funct7;
    logic [4:0]  e_out_rd, e_out_rs1, e_out_rs2;
    logic [2:0]  e_out_funct3;

    decode_regread_stage #(.XLEN(64), .NREGS(16)) dut16 (
        .clk(clk), .reset(e_reset), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .instruction(e_instruction), .flush(e_flush), .wr_en(e_wr_en), .wr_addr(e_wr_addr),
        .wr_data(e_wr_data), .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out_opcode(e_out_opcode), .out_rd(e_out_rd), .out_funct3(e_out_funct3),
        .out_funct7(e_out_funct7), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2),
        .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream table: rd, funct3, funct7 per instruction, all with rs1=x5, rs2=x0
    logic [4:0] s_rd [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
    logic [2:0] s_f3 [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [6:0] s_f7 [4] = '{7'h00, 7'h20, 7'h01, 7'h7f};

    initial begin
        reset = 1'b1; in_valid = 0; flush = 0; wr_en = 0; out_ready = 1;
        instruction = '0; wr_addr = '0; wr_data = '0;
        e_reset = 1'b1; e_in_valid = 0; e_flush = 0; e_wr_en = 0; e_out_ready = 1;
        e_instruction = '0; e_wr_addr = '0; e_wr_data = '0;
        tick();
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_rs1_data", out_rs1_data, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0; e_reset = 1'b0;

        // x5 = DEADBEEF, then add x1,x5,x0
        wr_en = 1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF;
        tick();
        wr_en = 0;
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1; instruction = 32'h0002_80B3;
        tick();
        in_valid = 0;
        check("add_out_valid", {63'd0, out_valid}, 64'd1);
        check("add_rs1", {59'd0, out_rs1}, 64'd5);
        check("add_rs1_data", out_rs1_data, 64'hDEAD_BEEF);
        check("add_rs2_data", out_rs2_data, 64'd0);
        check("add_rd", {59'd0, out_rd}, 64'd1);
        check("add_opcode", {57'd0, out_opcode}, 64'h33);
        tick();
        check("consume_out_valid", {63'd0, out_valid}, 64'd0);

        // Bypass: write x7 on the capture edge of add x2,x3,x7; then stall
        out_ready = 0;
        wr_en = 1; wr_addr = 5'd7; wr_data = 64'h1234;
        in_valid = 1; instruction = 32'h0071_8133;
        tick();
        check("byp_out_valid", {63'd0, out_valid}, 64'd1);
        check("byp_rs2_data", out_rs2_data, 64'h1234);
        check("byp_rs1_data", out_rs1_data, 64'd0);
        check("byp_in_ready", {63'd0, in_ready}, 64'd0);

        // Held-operand update: x3 = 0x55 while stalled, new instruction must not land
        wr_addr = 5'd3; wr_data = 64'h55;
        instruction = 32'h0000_04B3;
        tick();
        wr_en = 0;
        check("held_rs1_data", out_rs1_data, 64'h55);
        check("held_rs2_data", out_rs2_data, 64'h1234);
        check("held_rd", {59'd0, out_rd}, 64'd2);
        check("held_rs1", {59'd0, out_rs1}, 64'd3);
        check("held_in_ready", {63'd0, in_ready}, 64'd0);

        // Stream 4 instructions back to back
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            instruction = {s_f7[i], 5'd0, 5'd5, s_f3[i], s_rd[i], 7'h33};
            tick();
            check($sformatf("strm%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("strm%0d_rd", i), {59'd0, out_rd}, {59'd0, s_rd[i]});
            check($sformatf("strm%0d_f3", i), {61'd0, out_funct3}, {61'd0, s_f3[i]});
            check($sformatf("strm%0d_f7", i), {57'd0, out_funct7}, {57'd0, s_f7[i]});
            check($sformatf("strm%0d_rs1_data", i), out_rs1_data, 64'hDEAD_BEEF);
        end
        in_valid = 0;
        tick();
        check("strm_drain_valid", {63'd0, out_valid}, 64'd0);

        // x0 writes are dropped, including same-edge bypass
        wr_en = 1; wr_addr = 5'd0; wr_data = 64'hFFFF;
        tick();
        in_valid = 1; instruction = 32'h0000_0233;
        out_ready = 0;
        tick();
        in_valid = 0; wr_en = 0;
        check("x0_valid", {63'd0, out_valid}, 64'd1);
        check("x0_rs1_data", out_rs1_data, 64'd0);
        check("x0_rs2_data", out_rs2_data, 64'd0);

        // Flush while held: no capture, but the register write still happens
        flush = 1; in_valid = 1; instruction = 32'h0000_0633;
        wr_en = 1; wr_addr = 5'd6; wr_data = 64'h66;
        tick();
        flush = 0; in_valid = 0; wr_en = 0;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_rd_kept", {59'd0, out_rd}, 64'd4);
        tick();
        check("flush_no_capture", {63'd0, out_valid}, 64'd0);
        in_valid = 1; instruction = 32'h0003_00B3;
        tick();
        in_valid = 0;
        check("flush_write_kept", out_rs1_data, 64'h66);

        // Asynchronous reset in the middle of a stall
        #3 reset = 1'b1;
        #1;
        check("areset_valid", {63'd0, out_valid}, 64'd0);
        check("areset_rs1_data", out_rs1_data, 64'd0);
        check("areset_rd", {59'd0, out_rd}, 64'd0);
        #1 reset = 1'b0;
        in_valid = 1; instruction = 32'h0002_80B3;
        tick();
        in_valid = 0;
        check("post_reset_capture", {63'd0, out_valid}, 64'd1);
        check("post_reset_x5", out_rs1_data, 64'd0);

        // 16 registers: index 20 reads zero and is not an alias of x4
        e_wr_en = 1; e_wr_addr = 4'd4; e_wr_data = 64'hAAAA;
        tick();
        e_wr_en = 0;
        e_out_ready = 0; e_in_valid = 1; e_instruction = 32'h004A_0033;
        tick();
        e_in_valid = 0;
        check("n16_valid", {63'd0, e_out_valid}, 64'd1);
        check("n16_rs1", {59'd0, e_out_rs1}, 64'd20);
        check("n16_rs1_data", e_out_rs1_data, 64'd0);
        check("n16_rs2_data", e_out_rs2_data, 64'hAAAA);
        e_wr_en = 1; e_wr_data = 64'hBBBB;
        tick();
        e_wr_en = 0;
        check("n16_held_rs1", e_out_rs1_data, 64'd0);
        check("n16_held_rs2", e_out_rs2_data, 64'hBBBB);
        #3 e_reset = 1'b1;
        #1;
        check("n16_areset_valid", {63'd0, e_out_valid}, 64'd0);
        #1 e_reset = 1'b0;
        e_out_ready = 1; e_in_valid = 1; e_instruction = 32'h0040_0033;
        tick();
        e_in_valid = 0;
        check("n16_post_reset_x4", e_out_rs2_data, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
